diff_tx_serializer: RTL and testbench



---
 rtl/diff_tx_serializer.sv | 169 ++++++++++++++++
 tb/tb_diff_tx_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/diff_tx_serializer.sv
// Framed serial transmitter feeding an O_BUFT_DS pair: preamble, start, LSB-first data, optional even parity, stop.
// Pads are driven only while a frame is in flight; a word can be accepted in IDLE or in the last STOP cycle.
module diff_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  tx_data,
  output logic                  tx_oe,
  output logic                  busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_data_q, tx_data_d;
  logic                  tx_oe_q, tx_oe_d;
  logic                  busy_q, busy_d;
  logic                  s_ready_q, s_ready_d;
  logic                  bit_end;
  logic                  accept;

  assign bit_end = (clk_cnt_q == CLK_LAST);
  assign accept  = s_valid && s_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_data_q <= 1'b1;
      tx_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_data_q <= tx_data_d;
      tx_oe_q   <= tx_oe_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_data_d = tx_data_q;
    tx_oe_d   = tx_oe_q;

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        tx_oe_d   = 1'b0;
        tx_data_d = 1'b1;
        if (accept) begin
          state_d = PREAMBLE;
          tx_oe_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (bit_end) begin
          state_d   = START;
          tx_data_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_data_d = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d   = PARITY;
              tx_data_d = par_q;
            end else begin
              state_d   = STOP;
              tx_data_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_data_d = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          tx_data_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // A word taken here chains straight into the next start bit with the pads still driven.
          if (accept) begin
            state_d   = START;
            tx_data_d = 1'b0;
          end else begin
            state_d   = IDLE;
            tx_oe_d   = 1'b0;
            tx_data_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_oe_d   = 1'b0;
        tx_data_d = 1'b1;
      end
    endcase

    // s_ready_q is only high in IDLE or the last STOP cycle, so nothing is shifting when this fires.
    if (accept) begin
      shreg_d = s_data;
      par_d   = ^s_data;
    end

    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d == IDLE) || ((state_d == STOP) && (clk_cnt_d == CLK_LAST));
  end

  assign s_ready = s_ready_q;
  assign tx_data = tx_data_q;
  assign tx_oe   = tx_oe_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_diff_tx_serializer.sv
// Drives four parameterisations of diff_tx_serializer and compares every cycle of line activity
// against a per-cycle expected-sample queue built from the frame format.
module tb_diff_tx_serializer;

  localparam int NCFG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_dw(input int g);
    case (g)
      2:       return 1;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_cpb(input int g);
    case (g)
      2:       return 2;
      3:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_pe(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  for (genvar G = 0; G < NCFG; G++) begin : g_inst
    localparam int DW  = cfg_dw(G);
    localparam int CPB = cfg_cpb(G);
    localparam int PE  = cfg_pe(G);

    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready, tx_data, tx_oe, busy;

    diff_tx_serializer #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .s_data (s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .tx_data(tx_data),
      .tx_oe  (tx_oe),
      .busy   (busy)
    );

    // One entry per clock cycle still owed on the line: {oe, data}.
    logic [1:0] exp_q[$];
    bit         exp_rdy = 1'b1;
    int         acc_cnt = 0;
    int         qsz     = 0;
    bit         done    = 1'b0;

    task automatic add_bit(input logic v);
      repeat (CPB) exp_q.push_back({1'b1, v});
    endtask

    initial begin : model
      logic       acc;
      logic       was_idle;
      logic [1:0] head;
      forever begin
        @(posedge clk);
        if (rst) begin
          exp_q.delete();
        end else begin
          acc      = s_valid && exp_rdy;
          was_idle = (exp_q.size() == 0);
          if (!was_idle) void'(exp_q.pop_front());
          if (acc) begin
            if (was_idle) add_bit(1'b1);
            add_bit(1'b0);
            for (int i = 0; i < DW; i++) add_bit(s_data[i]);
            if (PE != 0) add_bit(^s_data);
            add_bit(1'b1);
            acc_cnt++;
          end
        end
        qsz     = exp_q.size();
        exp_rdy = rst || (qsz <= 1);
        #1;
        head = (qsz != 0) ? exp_q[0] : 2'b01;
        check_eq($sformatf("c%0d_oe@%0t", G, $time), tx_oe, head[1]);
        check_eq($sformatf("c%0d_data@%0t", G, $time), tx_data, head[0]);
        check_eq($sformatf("c%0d_busy@%0t", G, $time), busy, qsz != 0);
        check_eq($sformatf("c%0d_ready@%0t", G, $time), s_ready, exp_rdy);
      end
    end

    initial begin : drv
      logic [15:0] w[$];
      int          gp[$];
      logic [15:0] cur;
      int          start;
      if (G == 0) begin
        w.push_back(16'hA5); gp.push_back(3);
        w.push_back(16'h01); gp.push_back(5);
        w.push_back(16'h80); gp.push_back(0);
      end else if (G == 1) begin
        w.push_back(16'h07); gp.push_back(3);
        w.push_back(16'h03); gp.push_back(4);
        w.push_back(16'h07); gp.push_back(0);
      end else if (G == 2) begin
        w.push_back(16'h1);  gp.push_back(3);
        w.push_back(16'h1);  gp.push_back(4);
        w.push_back(16'h0);  gp.push_back(0);
      end else begin
        w.push_back(16'hBEEF); gp.push_back(2);
        w.push_back(16'h0001); gp.push_back(0);
      end
      for (int k = 0; k < 20; k++) begin
        w.push_back(16'($urandom));
        gp.push_back((k % 4 == 0) ? 0 : int'($urandom_range(1, 3)));
      end
      wait (go);
      @(negedge clk);
      for (int k = 0; k < w.size(); k++) begin
        if (gp[k] != 0) begin
          s_valid = 1'b0;
          repeat (gp[k]) @(negedge clk);
        end
        cur     = w[k];
        s_data  = cur[DW-1:0];
        s_valid = 1'b1;
        start   = acc_cnt;
        for (int c = 0; c < 400 && acc_cnt == start; c++) @(negedge clk);
        check_eq($sformatf("c%0d_accept_%0d", G, k), acc_cnt != start, 1);
      end
      s_valid = 1'b0;
      done    = 1'b1;
    end
  end

  initial begin : main
    logic all_done;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    go  = 1'b1;

    // Land the reset in the middle of a data field on the CLKS_PER_BIT=4 instance.
    for (int c = 0; c < 20000 && !(g_inst[0].acc_cnt >= 5 && g_inst[0].qsz == 20); c++)
      @(negedge clk);
    check_eq("mid_data_reached", g_inst[0].qsz, 20);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_oe", g_inst[0].tx_oe, 0);
    check_eq("rst_async_data", g_inst[0].tx_data, 1);
    check_eq("rst_async_busy", g_inst[0].busy, 0);
    check_eq("rst_async_ready", g_inst[0].s_ready, 1);
    check_eq("rst_async_oe_c3", g_inst[3].tx_oe, 0);
    check_eq("rst_async_data_c3", g_inst[3].tx_data, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    all_done = 1'b0;
    for (int c = 0; c < 20000 && !all_done; c++) begin
      @(negedge clk);
      all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done;
    end
    check_eq("drivers_done", all_done, 1);
    repeat (60) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
